// File: rtl/bitmode_sequencer.sv
// Bitmode pixel-access sequencer: owns the X/Y pixel address counters, steals
// non-video RAM slots for a nibble read-modify-write, then steps X/Y.
module bitmode_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic        video_slot,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_sel,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   output logic        busy,
   output logic [14:0] ram_addr,
   output logic        ram_re,
   output logic        ram_we,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout
);

   typedef enum logic [2:0] {
      IDLE, RD_WAIT, RD_DATA, WR_WAIT, STEP, ACK, DONE
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  x, y, rbuf;
   logic [3:0]  ctrl;      // {inc_y, inc_x, dir_y, dir_x}
   logic        op_we;
   logic [3:0]  op_din;

   function automatic logic [7:0] merge_nibble(input logic [7:0] b,
                                               input logic [3:0] n,
                                               input logic       hi);
      merge_nibble = hi ? {n, b[3:0]} : {b[7:4], n};
   endfunction

   function automatic logic [7:0] step8(input logic [7:0] v, input logic down);
      step8 = down ? v - 8'd1 : v + 8'd1;
   endfunction

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      case (state)
         IDLE:    if (cpu_req) state_nxt = (cpu_sel == 2'b00) ? RD_WAIT : ACK;
         RD_WAIT: if (!video_slot) begin
                     ram_re    = 1'b1;
                     state_nxt = RD_DATA;
                  end
         RD_DATA: state_nxt = op_we ? WR_WAIT : STEP;
         WR_WAIT: if (!video_slot) begin
                     ram_we    = 1'b1;
                     state_nxt = STEP;
                  end
         STEP:    state_nxt = ACK;
         ACK:     state_nxt = DONE;
         DONE:    if (!cpu_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Register file, read buffer and latched operation
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         x        <= 8'd0;
         y        <= 8'd0;
         ctrl     <= 4'd0;
         rbuf     <= 8'd0;
         op_we    <= 1'b0;
         op_din   <= 4'd0;
         cpu_dout <= 8'd0;
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               op_we  <= cpu_we;
               op_din <= cpu_din[3:0];
               if (cpu_we) begin
                  case (cpu_sel)
                     2'b01:   x    <= cpu_din;
                     2'b10:   y    <= cpu_din;
                     2'b11:   ctrl <= cpu_din[3:0];
                     default: ;
                  endcase
               end else begin
                  case (cpu_sel)
                     2'b01:   cpu_dout <= x;
                     2'b10:   cpu_dout <= y;
                     2'b11:   cpu_dout <= {4'b0, ctrl};
                     default: ;
                  endcase
               end
            end
            RD_DATA: begin
               rbuf <= ram_dout;
               if (!op_we) cpu_dout <= {4'b0, x[0] ? ram_dout[7:4] : ram_dout[3:0]};
            end
            STEP: begin
               if (ctrl[2]) x <= step8(x, ctrl[0]);
               if (ctrl[3]) y <= step8(y, ctrl[1]);
            end
            default: ;
         endcase
      end
   end

   // Address holds pre-step X/Y for every strobe since stepping follows the RAM phase
   assign ram_addr = {y, x[7:1]};
   assign ram_din  = merge_nibble(rbuf, op_din, x[0]);
   assign cpu_ack  = (state == ACK);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_bitmode_sequencer.sv
// Bench for bitmode_sequencer: directed vector table, reset/hold sequences and
// randomized accesses checked against a behavioural pixel-register model.
module tb_bitmode_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        video_slot = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [1:0]  cpu_sel = 2'b00;
   logic [7:0]  cpu_din = 8'h00;
   logic [7:0]  cpu_dout;
   logic        cpu_ack;
   logic        busy;
   logic [14:0] ram_addr;
   logic        ram_re;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout = 8'h00;

   bitmode_sequencer dut (
      .clk(clk), .clr(clr), .video_slot(video_slot), .cpu_req(cpu_req),
      .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .busy(busy),
      .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Bitmap RAM: one-cycle read latency
   logic [7:0] mem [0:32767];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] = ram_din;
      if (ram_re) ram_dout <= mem[ram_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;
   int strobe_bad = 0;

   always @(negedge clk) begin
      if (!clr && ((ram_re && ram_we) || ((ram_re || ram_we) && video_slot)))
         strobe_bad++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: registers and a shadow copy of the bitmap
   logic [7:0]  mmem [0:32767];
   int          mx, my, mctrl;
   logic [7:0]  m_dout, m_wdata;
   logic [14:0] m_addr;
   int          wr_q[$];

   task automatic model_apply(input logic [1:0] sel, input logic we, input logic [7:0] din);
      int addr, bytev, sh;
      if (sel == 2'b01) begin if (we) mx = din; else m_dout = 8'(mx); end
      else if (sel == 2'b10) begin if (we) my = din; else m_dout = 8'(my); end
      else if (sel == 2'b11) begin if (we) mctrl = din % 16; else m_dout = 8'(mctrl); end
      else begin
         addr   = my * 128 + mx / 2;
         m_addr = 15'(addr);
         bytev  = mmem[addr];
         sh     = 4 * (mx % 2);
         m_dout = 8'((bytev >> sh) % 16);
         if (we) begin
            m_wdata    = 8'((bytev & ~(15 << sh)) | ((din % 16) << sh));
            mmem[addr] = m_wdata;
            wr_q.push_back(addr);
         end
         if ((mctrl / 4) % 2 == 1) mx = (mx + ((mctrl % 2 == 1) ? 255 : 1)) % 256;
         if ((mctrl / 8) % 2 == 1) my = (my + (((mctrl / 2) % 2 == 1) ? 255 : 1)) % 256;
      end
   endtask

   // Ack cycle from the slot rules: read needs a free slot, the write needs a
   // free slot at least two cycles after the read strobe.
   function automatic int exp_ack(input logic [1:0] sel, input logic we, input logic [63:0] vm);
      int r, w;
      if (sel != 2'b00) return 1;
      r = 1;
      while (vm[r] && r < 60) r++;
      if (!we) return r + 3;
      w = r + 2;
      while (vm[w] && w < 60) w++;
      return w + 2;
   endfunction

   logic [7:0]  r_dout, r_wdata;
   logic [14:0] r_addr;
   int          r_ack;

   task automatic run_access(input logic [1:0] sel, input logic we, input logic [7:0] din,
                             input logic [63:0] vm, input int hold);
      bit done;
      @(negedge clk);
      cpu_req = 1'b1; cpu_sel = sel; cpu_we = we; cpu_din = din; video_slot = 1'b0;
      r_ack = -1; r_addr = 'x; r_wdata = 'x; r_dout = 'x;
      done = 1'b0;
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(posedge clk);
         #1 video_slot = vm[cyc];
         @(negedge clk);
         if (ram_re) r_addr = ram_addr;
         if (ram_we) r_wdata = ram_din;
         if (cpu_ack) begin
            r_ack = cyc; r_dout = cpu_dout; done = 1'b1;
         end
      end
      video_slot = 1'b0;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL ack_timeout: no cpu_ack within 60 cycles (sel %0d we %0d)", sel, we);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_busy", 32'(busy), 32'd1);
         chk("hold_no_reack", 32'(cpu_ack), 32'd0);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   task automatic do_op(input logic [1:0] sel, input logic we, input logic [7:0] din,
                        input logic [63:0] vm, input int hold);
      int ea;
      ea = exp_ack(sel, we, vm);
      model_apply(sel, we, din);
      run_access(sel, we, din, vm, hold);
      chk("ack_cycle", 32'(r_ack), 32'(ea));
      if (!we) chk("cpu_dout", 32'(r_dout), 32'(m_dout));
      if (sel == 2'b00) chk("ram_addr", 32'(r_addr), 32'(m_addr));
      if (sel == 2'b00 && we) chk("ram_din", 32'(r_wdata), 32'(m_wdata));
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic        we;
      logic [7:0]  din;
      logic [63:0] vm;
      logic        pre_en;
      logic [14:0] pre_addr;
      logic [7:0]  pre_val;
      int          ack;
      logic [7:0]  dout;
      logic [14:0] addr;
      logic [7:0]  wdata;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] sel, input logic we, input logic [7:0] din,
                               input logic [63:0] vm, input logic pre_en,
                               input logic [14:0] pa, input logic [7:0] pv, input int ack,
                               input logic [7:0] dout, input logic [14:0] addr,
                               input logic [7:0] wdata);
      vec_t v;
      v.sel = sel; v.we = we; v.din = din; v.vm = vm; v.pre_en = pre_en;
      v.pre_addr = pa; v.pre_val = pv; v.ack = ack; v.dout = dout;
      v.addr = addr; v.wdata = wdata;
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 32768; i++) begin
         mem[i]  = 8'((i * 37 + 11) ^ (i >> 7));
         mmem[i] = mem[i];
      end
      mx = 0; my = 0; mctrl = 0;

      // Power-on reset state
      repeat (2) @(negedge clk);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ram_re", 32'(ram_re), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_cpu_dout", 32'(cpu_dout), 0);
      chk("rst_ram_din", 32'(ram_din), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      clr = 1'b0;

      // Reset in the middle of a pixel write parked in WR_WAIT
      do_op(2'b01, 1'b1, 8'h33, 64'h0, 0);
      do_op(2'b10, 1'b1, 8'h44, 64'h0, 0);
      do_op(2'b11, 1'b1, 8'h04, 64'h0, 0);
      @(negedge clk);
      cpu_req = 1'b1; cpu_sel = 2'b00; cpu_we = 1'b1; cpu_din = 8'h07;
      @(posedge clk); #1 video_slot = 1'b0;
      @(posedge clk); #1 video_slot = 1'b1;
      @(posedge clk); #1 video_slot = 1'b1;
      @(negedge clk);
      chk("midwr_busy", 32'(busy), 1);
      chk("midwr_no_we", 32'(ram_we), 0);
      clr = 1'b1;
      #1;
      chk("clr_busy", 32'(busy), 0);
      chk("clr_ram_we", 32'(ram_we), 0);
      chk("clr_ram_re", 32'(ram_re), 0);
      chk("clr_cpu_ack", 32'(cpu_ack), 0);
      video_slot = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("clr_no_we", 32'(ram_we | cpu_ack), 0);
      end
      cpu_req = 1'b0;
      clr = 1'b0;
      mx = 0; my = 0; mctrl = 0;
      do_op(2'b01, 1'b0, 8'h00, 64'h0, 0);
      chk("clr_x_zero", 32'(r_dout), 0);
      do_op(2'b10, 1'b0, 8'h00, 64'h0, 0);
      chk("clr_y_zero", 32'(r_dout), 0);

      // Directed vectors
      tbl.push_back(mk(2'b01, 1, 8'h05, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b10, 1, 8'h10, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b11, 1, 8'h04, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b00, 1, 8'h0A, 0, 1, 15'h0802, 8'h3C, 5, 0, 15'h0802, 8'hAC));
      tbl.push_back(mk(2'b01, 0, 8'h00, 0, 0, 0, 0, 1, 8'h06, 0, 0));
      tbl.push_back(mk(2'b11, 1, 8'h05, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b01, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 8'h00, 0, 1, 15'h0800, 8'h7E, 4, 8'h0E, 15'h0800, 0));
      tbl.push_back(mk(2'b01, 0, 8'h00, 0, 0, 0, 0, 1, 8'hFF, 0, 0));
      tbl.push_back(mk(2'b11, 0, 8'h00, 0, 0, 0, 0, 1, 8'h05, 0, 0));
      tbl.push_back(mk(2'b11, 1, 8'h04, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b00, 1, 8'h05, 64'hCE, 1, 15'h087F, 8'h12, 10, 0, 15'h087F, 8'h52));
      tbl.push_back(mk(2'b01, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 0, 0));
      tbl.push_back(mk(2'b11, 1, 8'h0F, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b01, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b10, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(2'b00, 1, 8'h03, 0, 1, 15'h0000, 8'hFF, 5, 0, 15'h0000, 8'hF3));
      tbl.push_back(mk(2'b00, 1, 8'h09, 0, 1, 15'h7FFF, 8'h00, 5, 0, 15'h7FFF, 8'h90));
      tbl.push_back(mk(2'b01, 0, 8'h00, 0, 0, 0, 0, 1, 8'hFE, 0, 0));
      tbl.push_back(mk(2'b10, 0, 8'h00, 0, 0, 0, 0, 1, 8'hFE, 0, 0));

      foreach (tbl[i]) begin
         if (tbl[i].pre_en) begin
            mem[tbl[i].pre_addr]  = tbl[i].pre_val;
            mmem[tbl[i].pre_addr] = tbl[i].pre_val;
         end
         model_apply(tbl[i].sel, tbl[i].we, tbl[i].din);
         run_access(tbl[i].sel, tbl[i].we, tbl[i].din, tbl[i].vm, 0);
         chk($sformatf("vec%0d_ack", i), 32'(r_ack), 32'(tbl[i].ack));
         if (!tbl[i].we) chk($sformatf("vec%0d_dout", i), 32'(r_dout), 32'(tbl[i].dout));
         if (tbl[i].sel == 2'b00) chk($sformatf("vec%0d_addr", i), 32'(r_addr), 32'(tbl[i].addr));
         if (tbl[i].sel == 2'b00 && tbl[i].we)
            chk($sformatf("vec%0d_wdata", i), 32'(r_wdata), 32'(tbl[i].wdata));
      end

      // Request held four cycles past ack: one access, one step
      do_op(2'b00, 1'b1, 8'h06, 64'h0, 4);
      do_op(2'b01, 1'b0, 8'h00, 64'h0, 0);
      chk("hold_single_step_x", 32'(r_dout), 32'hFD);

      // Randomized accesses against the model
      for (int n = 0; n < 80; n++) begin
         logic [1:0]  s;
         logic        w;
         logic [7:0]  d;
         logic [63:0] vm;
         s  = 2'($urandom_range(0, 3));
         w  = 1'($urandom);
         d  = 8'($urandom);
         vm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         vm = vm & 64'h0000_0000_00FF_FFFF;
         do_op(s, w, d, vm, 0);
      end

      foreach (wr_q[i]) chk("mem_contents", 32'(mem[wr_q[i]]), 32'(mmem[wr_q[i]]));
      chk("strobe_rules", 32'(strobe_bad), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
